// File: rtl/cl_ocl_axil_pkg.sv
// Shared types and constants for the CL-side OCL AXI4-Lite initiator.
package cl_ocl_axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_AW_W,
    ST_WR_B,
    ST_RD_AR,
    ST_RD_R,
    ST_RSP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;

  // Word alignment check on the two low address bits.
  function automatic logic is_aligned(input logic [1:0] addr_lo);
    return addr_lo == 2'b00;
  endfunction

endpackage

// File: rtl/cl_ocl_axil_timeout_ctr.sv
// Loadable saturating 16-bit counter with a terminal-count flag; used to
// bound the wait for B/R responses.
module cl_ocl_axil_timeout_ctr #(
  parameter int unsigned TERMINAL = 1023
) (
  input  logic clk_main_a0,
  input  logic rst_main_n,
  input  logic load,
  input  logic en,
  output logic tc
);

  logic [15:0] count;

  // Clear on load, otherwise count up while enabled and stick at all-ones.
  // NOTE: sequential state is updated with <= only, so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

  assign tc = (count == 16'(TERMINAL));

endmodule

// File: rtl/cl_ocl_axil_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI-Lite read
// or write out, one completion back. Late responses after a timeout are
// drained before the next command is accepted.
module cl_ocl_axil_master
  import cl_ocl_axil_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic        clk_main_a0,
  input  logic        rst_main_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic        m_awvalid,
  output logic [31:0] m_awaddr,
  input  logic        m_awready,
  output logic        m_wvalid,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_wready,
  input  logic        m_bvalid,
  input  logic [1:0]  m_bresp,
  output logic        m_bready,
  output logic        m_arvalid,
  output logic [31:0] m_araddr,
  input  logic        m_arready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  output logic        m_rready,
  output logic        busy
);

  state_t state;
  cmd_t   cmd_q;
  logic   drain;
  logic   out_of_reset;
  logic   tc;
  logic   ctr_en;
  logic   aw_done;
  logic   w_done;

  // Address/data outputs come straight from the latched command flops.
  assign m_awaddr = cmd_q.addr;
  assign m_araddr = cmd_q.addr;
  assign m_wdata  = cmd_q.wdata;
  assign m_wstrb  = cmd_q.wstrb;

  // A channel is finished once its valid has dropped or is handshaking now.
  assign aw_done = !m_awvalid || m_awready;
  assign w_done  = !m_wvalid  || m_wready;

  // out_of_reset keeps cmd_ready low while reset is asserted.
  assign cmd_ready = out_of_reset && (state == ST_IDLE) && !drain;
  assign busy      = (state != ST_IDLE) || drain;

  // The response-wait counter runs only in the B/R wait states and is
  // held at zero elsewhere, so it starts from zero on every entry.
  assign ctr_en = (state == ST_WR_B) || (state == ST_RD_R);

  cl_ocl_axil_timeout_ctr #(
    .TERMINAL (TIMEOUT_CYCLES - 1)
  ) u_timeout_ctr (
    .clk_main_a0 (clk_main_a0),
    .rst_main_n  (rst_main_n),
    .load        (!ctr_en),
    .en          (ctr_en),
    .tc          (tc)
  );

  // Transaction FSM with registered AXI and response outputs.
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      state        <= ST_IDLE;
      cmd_q        <= '0;
      drain        <= 1'b0;
      out_of_reset <= 1'b0;
      m_awvalid    <= 1'b0;
      m_wvalid     <= 1'b0;
      m_bready     <= 1'b0;
      m_arvalid    <= 1'b0;
      m_rready     <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_resp     <= RESP_OKAY;
      rsp_timeout  <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;

      // Swallow the one late B or R owed by a timed-out transaction.
      if (drain && (cmd_q.write ? m_bvalid : m_rvalid)) begin
        drain    <= 1'b0;
        m_bready <= 1'b0;
        m_rready <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_q <= '{write: cmd_write, addr: cmd_addr,
                       wdata: cmd_wdata, wstrb: cmd_wstrb};
            if (!is_aligned(cmd_addr[1:0])) begin
              rsp_valid   <= 1'b1;
              rsp_resp    <= RESP_SLVERR;
              rsp_timeout <= 1'b0;
              rsp_rdata   <= cmd_write ? 32'h0 : TIMEOUT_RDATA;
              state       <= ST_RSP;
            end else if (cmd_write) begin
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              state     <= ST_WR_AW_W;
            end else begin
              m_arvalid <= 1'b1;
              state     <= ST_RD_AR;
            end
          end
        end

        ST_WR_AW_W: begin
          if (m_awvalid && m_awready) m_awvalid <= 1'b0;
          if (m_wvalid && m_wready)   m_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            m_bready <= 1'b1;
            state    <= ST_WR_B;
          end
        end

        ST_WR_B: begin
          if (m_bvalid) begin
            m_bready    <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_resp    <= m_bresp;
            rsp_rdata   <= 32'h0;
            rsp_timeout <= 1'b0;
            state       <= ST_RSP;
          end else if (tc) begin
            // Leave m_bready high so the late B is absorbed.
            drain       <= 1'b1;
            rsp_valid   <= 1'b1;
            rsp_resp    <= RESP_SLVERR;
            rsp_rdata   <= 32'h0;
            rsp_timeout <= 1'b1;
            state       <= ST_RSP;
          end
        end

        ST_RD_AR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= ST_RD_R;
          end
        end

        ST_RD_R: begin
          if (m_rvalid) begin
            m_rready    <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_resp    <= m_rresp;
            rsp_rdata   <= m_rdata;
            rsp_timeout <= 1'b0;
            state       <= ST_RSP;
          end else if (tc) begin
            drain       <= 1'b1;
            rsp_valid   <= 1'b1;
            rsp_resp    <= RESP_SLVERR;
            rsp_rdata   <= TIMEOUT_RDATA;
            rsp_timeout <= 1'b1;
            state       <= ST_RSP;
          end
        end

        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cl_ocl_axil_master.sv
// Directed bench for cl_ocl_axil_master with a small AXI-Lite register
// slave model. All sampling and driving happens on the falling edge.
module tb_cl_ocl_axil_master;
  import cl_ocl_axil_pkg::*;

  localparam int unsigned TO       = 16;
  localparam logic [31:0] TO_RDATA = 32'hDEAD_BEEF;

  logic        clk_main_a0 = 1'b0;
  logic        rst_main_n  = 1'b0;
  logic        cmd_valid   = 1'b0;
  logic        cmd_ready;
  logic        cmd_write   = 1'b0;
  logic [31:0] cmd_addr    = '0;
  logic [31:0] cmd_wdata   = '0;
  logic [3:0]  cmd_wstrb   = '0;
  logic        rsp_valid;
  logic        rsp_ready   = 1'b1;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready, busy;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_main_a0 = ~clk_main_a0;

  cl_ocl_axil_master #(
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_RDATA  (TO_RDATA)
  ) dut (
    .clk_main_a0 (clk_main_a0), .rst_main_n (rst_main_n),
    .cmd_valid   (cmd_valid),   .cmd_ready  (cmd_ready),
    .cmd_write   (cmd_write),   .cmd_addr   (cmd_addr),
    .cmd_wdata   (cmd_wdata),   .cmd_wstrb  (cmd_wstrb),
    .rsp_valid   (rsp_valid),   .rsp_ready  (rsp_ready),
    .rsp_rdata   (rsp_rdata),   .rsp_resp   (rsp_resp),
    .rsp_timeout (rsp_timeout),
    .m_awvalid   (m_awvalid),   .m_awaddr   (m_awaddr),  .m_awready (m_awready),
    .m_wvalid    (m_wvalid),    .m_wdata    (m_wdata),   .m_wstrb   (m_wstrb),
    .m_wready    (m_wready),
    .m_bvalid    (m_bvalid),    .m_bresp    (m_bresp),   .m_bready  (m_bready),
    .m_arvalid   (m_arvalid),   .m_araddr   (m_araddr),  .m_arready (m_arready),
    .m_rvalid    (m_rvalid),    .m_rdata    (m_rdata),   .m_rresp   (m_rresp),
    .m_rready    (m_rready),
    .busy        (busy)
  );

  logic [142:0] all_out;
  assign all_out = {cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
                    m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
                    m_arvalid, m_araddr, m_rready, busy};

  // ---------------- slave model ----------------
  logic        aw_ready_en = 1'b1;
  logic        w_ready_en  = 1'b1;
  logic        r_suppress  = 1'b0;
  logic        have_aw, have_w, have_ar;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  logic [31:0] mem [0:1023];
  int          write_count;

  assign m_awready = aw_ready_en;
  assign m_wready  = w_ready_en;
  assign m_arready = 1'b1;
  assign m_bresp   = RESP_OKAY;

  always @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      have_aw <= 1'b0; have_w <= 1'b0; have_ar <= 1'b0;
      m_bvalid <= 1'b0; m_rvalid <= 1'b0;
      m_rdata <= '0; m_rresp <= RESP_OKAY;
      s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0; s_araddr <= '0;
      write_count <= 0;
    end else begin
      if (m_awvalid && m_awready) begin have_aw <= 1'b1; s_awaddr <= m_awaddr; end
      if (m_wvalid && m_wready) begin have_w <= 1'b1; s_wdata <= m_wdata; s_wstrb <= m_wstrb; end
      if (m_bvalid && m_bready) m_bvalid <= 1'b0;
      if (have_aw && have_w) begin
        for (int b = 0; b < 4; b++)
          if (s_wstrb[b]) mem[s_awaddr[11:2]][8*b +: 8] <= s_wdata[8*b +: 8];
        have_aw <= 1'b0; have_w <= 1'b0;
        m_bvalid <= 1'b1;
        write_count <= write_count + 1;
      end
      if (m_arvalid && m_arready) begin have_ar <= 1'b1; s_araddr <= m_araddr; end
      if (m_rvalid && m_rready) m_rvalid <= 1'b0;
      if (have_ar && !r_suppress) begin
        m_rvalid <= 1'b1;
        m_rdata  <= mem[s_araddr[11:2]];
        m_rresp  <= (s_araddr == 32'h600) ? RESP_DECERR : RESP_OKAY;
        have_ar  <= 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  // Present a command and return at the falling edge right after acceptance.
  task automatic issue(input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    @(negedge clk_main_a0);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = data; cmd_wstrb = strb;
    while (!cmd_ready && n < 50) begin @(negedge clk_main_a0); n++; end
    if (!cmd_ready) begin
      n_checks++; n_fail++;
      $display("FAIL cmd_accept: cmd_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk_main_a0);
    @(negedge clk_main_a0);
    cmd_valid = 1'b0;
  endtask

  // k counts falling edges after the accept edge (1 = first one).
  task automatic wait_rsp(input int k0, output int k);
    k = k0;
    while (!rsp_valid && k < 200) begin @(negedge clk_main_a0); k++; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_main_n = 1'b0;
    repeat (2) @(negedge clk_main_a0);
    n_checks++;
    if (all_out !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
    rst_main_n = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready_pre: got %b expected 0", cmd_ready); end
    @(negedge clk_main_a0);
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_cmd_ready_post: got ready=%b busy=%b expected 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_write();
    int wc0 = write_count;
    issue(1'b1, 32'h500, 32'h1234_5678, 4'hF);
    n_checks++;
    if ({m_awvalid, m_wvalid, m_arvalid} !== 3'b110 || m_awaddr !== 32'h500 || m_wdata !== 32'h1234_5678 || m_wstrb !== 4'hF) begin
      n_fail++; $display("FAIL wr_addr_phase: got aw/w/ar=%b%b%b addr=%h data=%h strb=%h expected 110 500 12345678 f",
                         m_awvalid, m_wvalid, m_arvalid, m_awaddr, m_wdata, m_wstrb);
    end
    @(negedge clk_main_a0);
    n_checks++;
    if ({m_bready, m_awvalid, m_wvalid} !== 3'b100) begin
      n_fail++; $display("FAIL wr_bready: got bready/aw/w=%b%b%b expected 100", m_bready, m_awvalid, m_wvalid);
    end
    @(negedge clk_main_a0);
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_early: got %b expected 0", rsp_valid); end
    @(negedge clk_main_a0);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_resp !== RESP_OKAY || rsp_rdata !== 32'h0 || rsp_timeout !== 1'b0) begin
      n_fail++; $display("FAIL wr_rsp: got v=%b resp=%b rdata=%h to=%b expected 1 00 0 0",
                         rsp_valid, rsp_resp, rsp_rdata, rsp_timeout);
    end
    @(negedge clk_main_a0);
    n_checks++;
    if (mem[10'h140] !== 32'h1234_5678 || write_count !== wc0 + 1 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL wr_slave_reg: got mem=%h writes=%0d ready=%b expected 12345678 %0d 1",
                         mem[10'h140], write_count, cmd_ready, wc0 + 1);
    end
  endtask

  task automatic test_read();
    int k;
    issue(1'b0, 32'h500, 32'h0, 4'h0);
    n_checks++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h500 || m_awvalid !== 1'b0) begin
      n_fail++; $display("FAIL rd_ar: got arvalid=%b araddr=%h awvalid=%b expected 1 500 0", m_arvalid, m_araddr, m_awvalid);
    end
    wait_rsp(1, k);
    n_checks++;
    if (k !== 4) begin n_fail++; $display("FAIL rd_latency: got %0d expected 4", k); end
    n_checks++;
    if (rsp_rdata !== 32'h1234_5678 || rsp_resp !== RESP_OKAY || rsp_timeout !== 1'b0) begin
      n_fail++; $display("FAIL rd_rsp: got rdata=%h resp=%b to=%b expected 12345678 00 0", rsp_rdata, rsp_resp, rsp_timeout);
    end
    @(negedge clk_main_a0);
  endtask

  task automatic test_order(input logic w_first, input logic [31:0] addr, input logic [31:0] data);
    int  k;
    int  wc0 = write_count;
    logic held = 1'b1;
    aw_ready_en = !w_first;
    w_ready_en  = w_first;
    issue(1'b1, addr, data, 4'hF);
    n_checks++;
    if ({m_awvalid, m_wvalid} !== 2'b11) begin
      n_fail++; $display("FAIL order_valids_%0d: got %b%b expected 11", w_first, m_awvalid, m_wvalid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_main_a0);
      if (w_first) held &= (m_awvalid === 1'b1) && (m_wvalid === 1'b0);
      else         held &= (m_wvalid === 1'b1) && (m_awvalid === 1'b0);
    end
    n_checks++;
    if (!held) begin n_fail++; $display("FAIL order_hold_%0d: got stalled valid dropped expected held", w_first); end
    aw_ready_en = 1'b1;
    w_ready_en  = 1'b1;
    wait_rsp(4, k);
    n_checks++;
    if (k !== 7 || rsp_resp !== RESP_OKAY) begin
      n_fail++; $display("FAIL order_rsp_%0d: got k=%0d resp=%b expected 7 00", w_first, k, rsp_resp);
    end
    @(negedge clk_main_a0);
    n_checks++;
    if (mem[addr[11:2]] !== data || write_count !== wc0 + 1) begin
      n_fail++; $display("FAIL order_write_%0d: got mem=%h writes=%0d expected %h %0d",
                         w_first, mem[addr[11:2]], write_count, data, wc0 + 1);
    end
  endtask

  task automatic test_timeout_edge();
    int k = 1;
    r_suppress = 1'b1;
    issue(1'b0, 32'h504, 32'h0, 4'h0);
    while (k < 16) begin @(negedge clk_main_a0); k++; end
    r_suppress = 1'b0;
    wait_rsp(k, k);
    n_checks++;
    if (k !== 18 || rsp_resp !== RESP_OKAY || rsp_timeout !== 1'b0 || rsp_rdata !== 32'hA5A5_0001) begin
      n_fail++; $display("FAIL to_edge: got k=%0d resp=%b to=%b rdata=%h expected 18 00 0 a5a50001",
                         k, rsp_resp, rsp_timeout, rsp_rdata);
    end
    @(negedge clk_main_a0);
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL to_edge_nodrain: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_timeout();
    int   k;
    logic low = 1'b1;
    r_suppress = 1'b1;
    issue(1'b0, 32'h508, 32'h0, 4'h0);
    wait_rsp(1, k);
    n_checks++;
    if (k !== 18) begin n_fail++; $display("FAIL to_latency: got %0d expected 18", k); end
    n_checks++;
    if (rsp_resp !== RESP_SLVERR || rsp_timeout !== 1'b1 || rsp_rdata !== TO_RDATA) begin
      n_fail++; $display("FAIL to_rsp: got resp=%b to=%b rdata=%h expected 10 1 deadbeef", rsp_resp, rsp_timeout, rsp_rdata);
    end
    @(negedge clk_main_a0);
    n_checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1 || m_rready !== 1'b1) begin
      n_fail++; $display("FAIL to_drain: got ready=%b busy=%b rready=%b expected 0 1 1", cmd_ready, busy, m_rready);
    end
    repeat (3) begin @(negedge clk_main_a0); low &= (cmd_ready === 1'b0); end
    n_checks++;
    if (!low) begin n_fail++; $display("FAIL to_drain_hold: got cmd_ready high expected low"); end
    r_suppress = 1'b0;
    @(negedge clk_main_a0);
    n_checks++;
    if (cmd_ready !== 1'b0 || m_rvalid !== 1'b1) begin
      n_fail++; $display("FAIL to_late_r: got ready=%b rvalid=%b expected 0 1", cmd_ready, m_rvalid);
    end
    @(negedge clk_main_a0);
    n_checks++;
    if (cmd_ready !== 1'b1 || m_rready !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL to_drained: got ready=%b rready=%b busy=%b expected 1 0 0", cmd_ready, m_rready, busy);
    end
  endtask

  task automatic test_misaligned();
    int wc0 = write_count;
    issue(1'b0, 32'h502, 32'h0, 4'h0);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_resp !== RESP_SLVERR || rsp_rdata !== TO_RDATA || rsp_timeout !== 1'b0 || m_arvalid !== 1'b0) begin
      n_fail++; $display("FAIL mis_rd: got v=%b resp=%b rdata=%h to=%b ar=%b expected 1 10 deadbeef 0 0",
                         rsp_valid, rsp_resp, rsp_rdata, rsp_timeout, m_arvalid);
    end
    issue(1'b1, 32'h507, 32'hFFFF_FFFF, 4'hF);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_resp !== RESP_SLVERR || rsp_rdata !== 32'h0 || {m_awvalid, m_wvalid} !== 2'b00) begin
      n_fail++; $display("FAIL mis_wr: got v=%b resp=%b rdata=%h aw/w=%b%b expected 1 10 0 00",
                         rsp_valid, rsp_resp, rsp_rdata, m_awvalid, m_wvalid);
    end
    repeat (3) @(negedge clk_main_a0);
    n_checks++;
    if (write_count !== wc0 || m_arvalid !== 1'b0) begin
      n_fail++; $display("FAIL mis_no_bus: got writes=%0d ar=%b expected %0d 0", write_count, m_arvalid, wc0);
    end
  endtask

  task automatic test_decerr();
    int k;
    issue(1'b0, 32'h600, 32'h0, 4'h0);
    wait_rsp(1, k);
    n_checks++;
    if (k !== 4 || rsp_resp !== RESP_DECERR || rsp_timeout !== 1'b0) begin
      n_fail++; $display("FAIL decerr: got k=%0d resp=%b to=%b expected 4 11 0", k, rsp_resp, rsp_timeout);
    end
    @(negedge clk_main_a0);
  endtask

  task automatic test_hold_and_reset();
    int   k;
    logic stable = 1'b1;
    rsp_ready = 1'b0;
    issue(1'b0, 32'h500, 32'h0, 4'h0);
    wait_rsp(1, k);
    repeat (10) begin
      @(negedge clk_main_a0);
      stable &= (rsp_valid === 1'b1) && (rsp_rdata === 32'h1234_5678) &&
                (rsp_resp === RESP_OKAY) && (cmd_ready === 1'b0);
    end
    n_checks++;
    if (!stable) begin n_fail++; $display("FAIL hold_stable: got rsp fields changed expected held"); end
    rsp_ready = 1'b1;
    @(negedge clk_main_a0);
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release: got %b expected 0", rsp_valid); end
    aw_ready_en = 1'b0;
    issue(1'b1, 32'h510, 32'h0BAD_F00D, 4'hF);
    repeat (2) @(negedge clk_main_a0);
    n_checks++;
    if (m_awvalid !== 1'b1) begin n_fail++; $display("FAIL pend_aw: got %b expected 1", m_awvalid); end
    #2 rst_main_n = 1'b0;
    #1;
    n_checks++;
    if (all_out !== '0) begin n_fail++; $display("FAIL async_reset: got %h expected 0", all_out); end
    @(negedge clk_main_a0);
    rst_main_n  = 1'b1;
    aw_ready_en = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_release_pre: got %b expected 0", cmd_ready); end
    @(negedge clk_main_a0);
    n_checks++;
    if (cmd_ready !== 1'b1 || m_awvalid !== 1'b0) begin
      n_fail++; $display("FAIL rst_release_post: got ready=%b aw=%b expected 1 0", cmd_ready, m_awvalid);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_order(1'b1, 32'h504, 32'hA5A5_0001);
    test_order(1'b0, 32'h508, 32'h5A5A_0002);
    test_timeout_edge();
    test_timeout();
    test_misaligned();
    test_decerr();
    test_hold_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cl_ocl_axil_master.md
Name: cl_ocl_axil_master

Overview:
- Single-outstanding AXI4-Lite initiator for the CL-side OCL-style register interface.
- Turns a simple command (valid/ready) into one AXI-Lite read or write on the master port, then returns the completion on a response channel (valid/ready).
- Drives on-chip AXI-Lite register slaves, such as hello-world style register/BRAM blocks, from internal sequencers and self-test logic.
- Sits in front of an axi_register_slice_light, which is instantiated outside this block.

Parameters:
- TIMEOUT_CYCLES, 1024: response-wait limit in clk_main_a0 cycles; legal range 2..65535.
- TIMEOUT_RDATA, 32'hDEAD_BEEF: value returned as rsp_rdata on a read timeout or a misaligned read.

Ports:
- clk_main_a0  in  1  clock.
- rst_main_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  AXI response code, or 2'b10 on local error.
- rsp_timeout  out  1  response generated by timeout.
- m_awvalid  out  1  AW valid.
- m_awaddr  out  32  AW address.
- m_awready  in  1  AW ready.
- m_wvalid  out  1  W valid.
- m_wdata  out  32  W data.
- m_wstrb  out  4  W strobes.
- m_wready  in  1  W ready.
- m_bvalid  in  1  B valid.
- m_bresp  in  2  B response.
- m_bready  out  1  B ready.
- m_arvalid  out  1  AR valid.
- m_araddr  out  32  AR address.
- m_arready  in  1  AR ready.
- m_rvalid  in  1  R valid.
- m_rdata  in  32  R data.
- m_rresp  in  2  R response.
- m_rready  out  1  R ready.
- busy  out  1  high whenever the FSM is not in IDLE or drain is pending.

Behaviour:
Reset and ownership
- Reset is rst_main_n, asynchronous, active-low; clock is clk_main_a0. Every flop clears on reset.
- All outputs are 0 in reset, including cmd_ready.
- cmd_ready = (state==IDLE) && !drain, and is high from the first clock after reset release.
- All m_* outputs and rsp_* outputs are registered.

Command acceptance
- A command is accepted at cycle T when cmd_valid && cmd_ready.
- The address, data, strobes and direction are latched at T.
- cmd_* inputs are ignored while cmd_ready is low.

FSM states: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
- IDLE, write accepted: go to WR_AW_W. m_awvalid and m_wvalid both rise at T+1.
- WR_AW_W: each valid drops on its own handshake. AW and W may complete in either order or in the same cycle. Go to WR_B once both are done. m_bready rises on entry to WR_B.
- IDLE, read accepted: go to RD_AR. m_arvalid rises at T+1.
- RD_AR: on the AR handshake, go to RD_R with m_rready high.
- WR_B / RD_R: on the B or R handshake:
  - capture m_bresp or m_rresp (and m_rdata for reads);
  - drop ready;
  - go to RSP.
- RSP: rsp_valid is high. rsp_* fields are held stable until rsp_ready. On rsp_ready, return to IDLE; a new command can be accepted on the next cycle.
- Minimum latency with a zero-wait slave: command accept at T, rsp_valid at T+4.

AXI rules
- Valids are never deasserted before their handshake.
- Address-phase states wait indefinitely; no timeout applies there.
- The block never presents AW and AR at the same time.

Timeout
- A 16-bit counter is cleared on entry to WR_B or RD_R and increments every cycle in that state.
- When the counter reaches TIMEOUT_CYCLES-1 with no handshake:
  - go to RSP;
  - rsp_resp = 2'b10 and rsp_timeout = 1;
  - rsp_rdata = TIMEOUT_RDATA for reads, 0 for writes;
  - set drain.
- If the handshake occurs in that same last cycle, the handshake wins and no timeout is raised.

Drain
- While drain is set, in IDLE or RSP, the block holds m_bready (write timeout) or m_rready (read timeout) high.
- It discards exactly one late B or R, then clears drain.
- cmd_ready stays low until drain clears.

Misaligned address
- A command with cmd_addr[1:0] != 0 produces no bus activity.
- The block goes directly to RSP at T+1 with rsp_resp = 2'b10 and rsp_timeout = 0.
- rsp_rdata = TIMEOUT_RDATA for reads, 0 for writes.

Response codes
- Non-OKAY slave responses (SLVERR, DECERR) are passed through unchanged.

Reset mid-transaction
- All valids and readies drop asynchronously and the FSM returns to IDLE.
- The slave is reset by the same rst_main_n.

Decomposition:
- Shared package cl_ocl_axil_pkg:
  - typedef enum for the FSM states;
  - localparams RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - packed struct cmd_t {write, addr, wdata, wstrb}.
- One natural sub-module: cl_ocl_axil_timeout_ctr, a loadable saturating counter with a terminal-count flag.

Test Plan:
- Write 0x500 ← 0x1234_5678, wstrb F, zero-wait slave → AW/W valid at T+1, bready at T+2, rsp_valid at T+4, rsp_resp 0, rsp_rdata 0; slave register = 0x1234_5678.
- Read 0x500 after that write → m_araddr 0x500, rsp_rdata 0x1234_5678, rsp_resp 0, rsp_timeout 0.
- Slave asserts wready 3 cycles before awready, then in a second run awready first → exactly one write completes each time; no valid is dropped early.
- Slave never returns R, TIMEOUT_CYCLES=16 → rsp_valid 16 cycles after AR handshake, rsp_resp 2'b10, rsp_timeout 1, rdata 0xDEAD_BEEF; then late R injected → cmd_ready stays low until R is consumed, then returns high.
- Read 0x502 → no m_arvalid ever; rsp_valid at T+1 with resp 2'b10 and rdata 0xDEAD_BEEF. Slave returns DECERR on 0x600 → rsp_resp 2'b11 propagated.
- rsp_ready held low 10 cycles, then rst_main_n pulsed during a pending AW → rsp fields stable while waiting; on reset all outputs go to 0 immediately and cmd_ready = 1 one cycle after release.
